decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- IF→ID pipeline stage of the RV32I core, directly upstream of the immediate generator.
- Accepts fetched instruction/PC over a valid/ready handshake and decodes the opcode into imm_type and control bits.
- Slices instr[31:7] into the 25-bit immediate field the generator consumes.
- Buffers up to two instructions (main + skid) so if_ready is a registered signal; supports pipeline flush.

Parameters:
- XLEN, 32, data/PC width.
- IMM_W, 25, immediate field width (32 minus the 7-bit opcode).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  stage can accept (registered)
- if_instr  in  32  raw instruction
- if_pc  in  XLEN  PC of if_instr
- flush  in  1  discard all buffered instructions (branch redirect)
- id_valid  out  1  decoded instruction on id_* outputs
- id_ready  in  1  downstream accepts
- id_pc  out  XLEN  PC
- id_in_imm  out  25  instr[31:7]
- id_imm_type  out  3  0=I, 1=B, 2=S, 3=U, 4=J, 7=none
- id_rs1, id_rs2, id_rd  out  5 each  register indices
- id_funct3  out  3; id_funct7b5  out  1  (instr[30])
- id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_alu_src_imm  out  1 each
- id_illegal  out  1  unsupported opcode or instr[1:0]≠2'b11

Behaviour:
- Decode is combinational on if_instr; results are registered at capture. Accepting at edge N places the instruction on id_* from edge N onward (1-cycle latency).
- Opcode map (reg_write / mem_read / mem_write / branch / jump / alu_src_imm):
  - LUI 0110111, AUIPC 0010111: U type; reg_write=1, alu_src_imm=1.
  - JAL 1101111: J type; reg_write=1, jump=1.
  - JALR 1100111: I type; reg_write=1, jump=1, alu_src_imm=1.
  - BRANCH 1100011: B type; branch=1.
  - LOAD 0000011: I type; reg_write=1, mem_read=1, alu_src_imm=1.
  - STORE 0100011: S type; mem_write=1, alu_src_imm=1.
  - OP-IMM 0010011: I type; reg_write=1, alu_src_imm=1.
  - OP 0110011: type 7 (none); reg_write=1.
  - FENCE 0001111, SYSTEM 1110011: I type; all control bits 0.
  - Anything else: type 7, all control bits 0, id_illegal=1. Still passed downstream with id_valid=1.
- FSM states:
  - EMPTY: id_valid=0.
  - ONE: main register valid.
  - TWO: main and skid registers valid.
- Handshakes: accept = if_valid & if_ready; deliver = id_valid & id_ready.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE: accept & deliver → ONE (main replaced); accept only → TWO (new instruction into skid); deliver only → EMPTY.
  - TWO: deliver → ONE (skid moves to main). Accept cannot occur in TWO.
- if_ready is registered: it equals 1 in the next cycle iff the next state ≠ TWO.
- Flush has priority over accept and deliver in the same cycle: next state EMPTY, if_ready=1, any same-cycle accepted instruction dropped.
- id_* outputs hold stable while id_valid=1 and id_ready=0.
- Reset, including mid-operation: state EMPTY, if_ready=1, id_valid=0, all id_* data/control outputs 0. id_imm_type resets to 3'b111.
- Order is preserved: the skid entry is never delivered before the main entry.

Decomposition:
- Shared package/include: opcode constants, imm_type encodings (I/B/S/U/J/none), control-bit bundle layout.
- Sub-module: opcode_decoder (pure combinational instr→fields/control), instantiated once at the capture input.
- Storage and FSM stay in decode_stage.

Test Plan:
1. Reset then if_instr=32'h00500093 (addi x1,x0,5), pc=0, id_ready=1 → next cycle id_valid=1, imm_type=0, rd=1, rs1=0, in_imm=25'h00A001, reg_write=1, alu_src_imm=1.
2. Back-to-back sw 32'h00112223, beq 32'h00208463, jal 32'h008000EF, lui 32'h123450B7 with id_ready=1 → imm_types 2,1,4,3 in order on consecutive cycles; mem_write, branch, jump, reg_write flags correct.
3. id_ready=0 with 3 if_valid offers → 2 accepted, if_ready=0 from the cycle after the second. Raise id_ready → both delivered in order, if_ready returns to 1.
4. Flush asserted in state TWO, simultaneous with if_valid → next cycle id_valid=0, if_ready=1, no instruction ever delivered for any of the three.
5. if_instr=32'h0000007F and 32'h00000000 → id_illegal=1, id_imm_type=7, all control bits 0, id_valid=1.
6. rst asserted in state TWO with id_ready=0 → next cycle all outputs at reset values; first post-reset accept delivered correctly.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - opcode constants, immediate types and decoded-field layout for the decode stage
package decode_stage_pkg;

   localparam int IMM_W = 25;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_B    = 3'd1,
      IMM_S    = 3'd2,
      IMM_U    = 3'd3,
      IMM_J    = 3'd4,
      IMM_NONE = 3'd7
   } imm_type_e;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_e;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic branch;
      logic jump;
      logic alu_src_imm;
   } ctrl_t;

   typedef struct packed {
      imm_type_e        imm_type;
      logic [IMM_W-1:0] in_imm;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic [2:0]       funct3;
      logic             funct7b5;
      ctrl_t            ctrl;
      logic             illegal;
   } dec_t;

   function automatic ctrl_t mk_ctrl(input logic rw, input logic mr, input logic mw,
                                     input logic br, input logic jp, input logic ai);
      ctrl_t c;
      c.reg_write   = rw;
      c.mem_read    = mr;
      c.mem_write   = mw;
      c.branch      = br;
      c.jump        = jp;
      c.alu_src_imm = ai;
      return c;
   endfunction

   // Reset image of a decoded slot: everything zero except "no immediate".
   function automatic dec_t dec_reset();
      dec_t d;
      d          = '0;
      d.imm_type = IMM_NONE;
      return d;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and decode-side handshake bundle of the decode stage
interface decode_stage_if
   import decode_stage_pkg::*;
#(
   parameter int XLEN = 32
);
   logic             if_valid;
   logic             if_ready;
   logic [31:0]      if_instr;
   logic [XLEN-1:0]  if_pc;
   logic             flush;

   logic             id_valid;
   logic             id_ready;
   logic [XLEN-1:0]  id_pc;
   logic [IMM_W-1:0] id_in_imm;
   logic [2:0]       id_imm_type;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic [4:0]       id_rd;
   logic [2:0]       id_funct3;
   logic             id_funct7b5;
   logic             id_reg_write;
   logic             id_mem_read;
   logic             id_mem_write;
   logic             id_branch;
   logic             id_jump;
   logic             id_alu_src_imm;
   logic             id_illegal;

   modport master (
      input  if_valid, if_instr, if_pc, flush, id_ready,
      output if_ready, id_valid, id_pc, id_in_imm, id_imm_type,
             id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
             id_reg_write, id_mem_read, id_mem_write, id_branch,
             id_jump, id_alu_src_imm, id_illegal
   );

   modport slave (
      output if_valid, if_instr, if_pc, flush, id_ready,
      input  if_ready, id_valid, id_pc, id_in_imm, id_imm_type,
             id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
             id_reg_write, id_mem_read, id_mem_write, id_branch,
             id_jump, id_alu_src_imm, id_illegal
   );
endinterface

// File: rtl/decode_stage_opcode_decoder.sv
// rtl/decode_stage_opcode_decoder.sv - combinational RV32I opcode to fields/control decode
module decode_stage_opcode_decoder
   import decode_stage_pkg::*;
(
   input  logic [31:0] instr,
   output dec_t        dec
);

   always_comb begin
      dec.in_imm   = instr[31:7];
      dec.rs1      = instr[19:15];
      dec.rs2      = instr[24:20];
      dec.rd       = instr[11:7];
      dec.funct3   = instr[14:12];
      dec.funct7b5 = instr[30];
      dec.imm_type = IMM_NONE;
      dec.ctrl     = '0;
      dec.illegal  = 1'b0;

      // Every supported opcode ends in 2'b11, so compressed encodings land in default.
      case (instr[6:0])
         OP_LUI, OP_AUIPC: begin
            dec.imm_type = IMM_U;
            dec.ctrl     = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         end
         OP_JAL: begin
            dec.imm_type = IMM_J;
            dec.ctrl     = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         end
         OP_JALR: begin
            dec.imm_type = IMM_I;
            dec.ctrl     = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         end
         OP_BRANCH: begin
            dec.imm_type = IMM_B;
            dec.ctrl     = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         end
         OP_LOAD: begin
            dec.imm_type = IMM_I;
            dec.ctrl     = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
         end
         OP_STORE: begin
            dec.imm_type = IMM_S;
            dec.ctrl     = mk_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
         end
         OP_IMM: begin
            dec.imm_type = IMM_I;
            dec.ctrl     = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         end
         OP_OP: begin
            dec.imm_type = IMM_NONE;
            dec.ctrl     = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         end
         OP_FENCE, OP_SYSTEM: begin
            dec.imm_type = IMM_I;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - IF to ID pipeline stage with main+skid buffering and flush
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int XLEN = 32
)(
   input  logic          clk,
   input  logic          rst,
   decode_stage_if.master bus
);

   state_e          state;
   state_e          state_nxt;
   logic            if_ready_q;
   logic            accept;
   logic            deliver;
   logic            load_main;
   logic            load_skid;
   logic            move_skid;

   dec_t            new_dec;
   dec_t            main_dec;
   dec_t            skid_dec;
   logic [XLEN-1:0] main_pc;
   logic [XLEN-1:0] skid_pc;

   decode_stage_opcode_decoder u_dec (
      .instr (bus.if_instr),
      .dec   (new_dec)
   );

   assign accept  = bus.if_valid & if_ready_q;
   assign deliver = (state != S_EMPTY) & bus.id_ready;

   always_comb begin
      state_nxt = state;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
      if (bus.flush) begin
         state_nxt = S_EMPTY;
      end else begin
         case (state)
            S_EMPTY: begin
               if (accept) begin
                  state_nxt = S_ONE;
                  load_main = 1'b1;
               end
            end
            S_ONE: begin
               if (accept && deliver) begin
                  load_main = 1'b1;
               end else if (accept) begin
                  state_nxt = S_TWO;
                  load_skid = 1'b1;
               end else if (deliver) begin
                  state_nxt = S_EMPTY;
               end
            end
            S_TWO: begin
               // if_ready is low here, so only a delivery can move us.
               if (deliver) begin
                  state_nxt = S_ONE;
                  move_skid = 1'b1;
               end
            end
            default: state_nxt = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_EMPTY;
         if_ready_q <= 1'b1;
      end else begin
         state      <= state_nxt;
         if_ready_q <= (state_nxt != S_TWO);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_dec <= dec_reset();
         skid_dec <= dec_reset();
         main_pc  <= '0;
         skid_pc  <= '0;
      end else begin
         if (load_main) begin
            main_dec <= new_dec;
            main_pc  <= bus.if_pc;
         end else if (move_skid) begin
            main_dec <= skid_dec;
            main_pc  <= skid_pc;
         end
         if (load_skid) begin
            skid_dec <= new_dec;
            skid_pc  <= bus.if_pc;
         end
      end
   end

   assign bus.if_ready       = if_ready_q;
   assign bus.id_valid       = (state != S_EMPTY);
   assign bus.id_pc          = main_pc;
   assign bus.id_in_imm      = main_dec.in_imm;
   assign bus.id_imm_type    = main_dec.imm_type;
   assign bus.id_rs1         = main_dec.rs1;
   assign bus.id_rs2         = main_dec.rs2;
   assign bus.id_rd          = main_dec.rd;
   assign bus.id_funct3      = main_dec.funct3;
   assign bus.id_funct7b5    = main_dec.funct7b5;
   assign bus.id_reg_write   = main_dec.ctrl.reg_write;
   assign bus.id_mem_read    = main_dec.ctrl.mem_read;
   assign bus.id_mem_write   = main_dec.ctrl.mem_write;
   assign bus.id_branch      = main_dec.ctrl.branch;
   assign bus.id_jump        = main_dec.ctrl.jump;
   assign bus.id_alu_src_imm = main_dec.ctrl.alu_src_imm;
   assign bus.id_illegal     = main_dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized self-checking bench for decode_stage against a queue model
module tb_decode_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   decode_stage_if #(.XLEN(32)) bus();

   decode_stage #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          total = 0;
   int          bad   = 0;
   logic [63:0] q[$];
   logic        m_ready = 1'b1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected {imm_type, rw, mr, mw, br, jp, ai, illegal} from the opcode table.
   function automatic logic [9:0] ref_ctl(input logic [31:0] ins);
      if (ins[1:0] != 2'b11) return {3'd7, 6'b000000, 1'b1};
      case (ins[6:0])
         7'b0110111, 7'b0010111: return {3'd3, 6'b100001, 1'b0};
         7'b1101111:             return {3'd4, 6'b100010, 1'b0};
         7'b1100111:             return {3'd0, 6'b100011, 1'b0};
         7'b1100011:             return {3'd1, 6'b000100, 1'b0};
         7'b0000011:             return {3'd0, 6'b110001, 1'b0};
         7'b0100011:             return {3'd2, 6'b001001, 1'b0};
         7'b0010011:             return {3'd0, 6'b100001, 1'b0};
         7'b0110011:             return {3'd7, 6'b100000, 1'b0};
         7'b0001111, 7'b1110011: return {3'd0, 6'b000000, 1'b0};
         default:                return {3'd7, 6'b000000, 1'b1};
      endcase
   endfunction

   function automatic logic [43:0] ref_fields(input logic [31:0] ins);
      return {ins[31:7], ins[19:15], ins[24:20], ins[11:7], ins[14:12], ins[30]};
   endfunction

   function automatic logic [9:0] dut_ctl();
      return {bus.id_imm_type, bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
              bus.id_branch, bus.id_jump, bus.id_alu_src_imm, bus.id_illegal};
   endfunction

   function automatic logic [43:0] dut_fields();
      return {bus.id_in_imm, bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_funct3, bus.id_funct7b5};
   endfunction

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl);
      bus.if_valid = v;
      bus.if_instr = ins;
      bus.if_pc    = pc;
      bus.id_ready = rdy;
      bus.flush    = fl;
   endtask

   task automatic check_now();
      chk("if_ready", bus.if_ready, m_ready);
      chk("id_valid", bus.id_valid, q.size() != 0);
      if (q.size() != 0) begin
         chk("id_pc", bus.id_pc, q[0][63:32]);
         chk("id_fields", dut_fields(), ref_fields(q[0][31:0]));
         chk("id_ctl", dut_ctl(), ref_ctl(q[0][31:0]));
      end
   endtask

   task automatic check_reset();
      chk("rst_pc", bus.id_pc, 0);
      chk("rst_fields", dut_fields(), 0);
      chk("rst_ctl", dut_ctl(), {3'd7, 7'd0});
   endtask

   task automatic cycle();
      logic acc;
      logic del;
      logic was_rst;
      acc     = bus.if_valid & m_ready;
      del     = bus.id_ready && (q.size() != 0);
      was_rst = rst;
      @(posedge clk);
      if (rst || bus.flush) begin
         q.delete();
         m_ready = 1'b1;
      end else begin
         if (del) void'(q.pop_front());
         if (acc) q.push_back({bus.if_pc, bus.if_instr});
         m_ready = (q.size() < 2);
      end
      @(negedge clk);
      check_now();
      if (was_rst) check_reset();
   endtask

   logic [31:0] t2_ins  [4];
   logic [2:0]  t2_type [4];
   logic [6:0]  ops     [11];

   initial begin
      t2_ins  = '{32'h00112223, 32'h00208463, 32'h008000EF, 32'h123450B7};
      t2_type = '{3'd2, 3'd1, 3'd4, 3'd3};
      ops     = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                  7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};

      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;

      drive(1'b1, 32'h00500093, 32'h0, 1'b1, 1'b0);
      cycle();
      chk("t1_imm", bus.id_in_imm, 25'h00A001);
      chk("t1_type", bus.id_imm_type, 3'd0);
      chk("t1_rd", bus.id_rd, 5'd1);

      for (int i = 0; i < 4; i++) begin
         drive(1'b1, t2_ins[i], 32'h100 + 32'(4 * i), 1'b1, 1'b0);
         cycle();
         chk("t2_type", bus.id_imm_type, t2_type[i]);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle();

      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h00A00113 + 32'(i << 20), 32'h200 + 32'(4 * i), 1'b0, 1'b0);
         cycle();
      end
      chk("t3_stall", bus.if_ready, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle();
      chk("t3_ready_back", bus.if_ready, 1'b1);

      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h00002083 + 32'(i << 7), 32'h300 + 32'(4 * i), 1'b0, 1'b0);
         cycle();
      end
      drive(1'b1, 32'h00310233, 32'h308, 1'b0, 1'b1);
      cycle();
      chk("t4_valid", bus.id_valid, 1'b0);
      chk("t4_ready", bus.if_ready, 1'b1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle();
      cycle();

      drive(1'b1, 32'h0000007F, 32'h400, 1'b1, 1'b0);
      cycle();
      chk("t5a_ill", {bus.id_valid, bus.id_illegal, bus.id_imm_type}, {1'b1, 1'b1, 3'd7});
      drive(1'b1, 32'h00000000, 32'h404, 1'b1, 1'b0);
      cycle();
      chk("t5b_ill", dut_ctl(), {3'd7, 6'd0, 1'b1});

      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h123450B7, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
         cycle();
      end
      rst = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      cycle();
      rst = 1'b0;
      drive(1'b1, 32'h00500093, 32'h600, 1'b1, 1'b0);
      cycle();
      chk("t6_pc", bus.id_pc, 32'h600);

      for (int n = 0; n < 800; n++) begin
         logic [31:0] r;
         logic [31:0] ins;
         r   = $urandom;
         ins = ($urandom_range(0, 7) == 0) ? r : {r[31:7], ops[$urandom_range(0, 10)]};
         rst = ($urandom_range(0, 63) == 0);
         drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 2) != 0,
               $urandom_range(0, 15) == 0);
         cycle();
      end
      rst = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
